// File: rtl/hazard_fwd_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_fwd_ctrl
//
// Hazard and forwarding controller for the 5-stage MIPS pipeline.
//
// The block keeps its own copy of the EX-stage source registers (exRs/exRt
// plus their "actually read" flags). It compares them against the MEM and WB
// destinations to steer the two ALU operand multiplexors. It also detects
// two kinds of ID-stage hazard:
//   - load-use: the instruction in EX is a load whose destination the ID
//     instruction reads.
//   - mult/div: the ID instruction needs HI/LO or the MD unit while that unit
//     is busy, or while a mult/div is starting in EX this cycle.
// Either hazard freezes PC and IF/ID (oStall) and injects a bubble into ID/EX
// (oBubble). Both hazards at the same time produce a single stall.
//
// Ports
//   iClk          core clock, all state on the rising edge
//   iReset        synchronous reset, active high
//   iIdRs/iIdRt   ID-stage source register addresses
//   iIdUseRs/Rt   ID instruction really reads rs / rt
//   iIdMdUse      ID instruction is mfhi/mflo/mult/div
//   iExRd         EX-stage destination register
//   iExMemRead    EX instruction is a load
//   iExRegWrite   EX instruction writes the register file
//   iMemRd        MEM-stage destination register
//   iMemRegWrite  MEM instruction writes the register file
//   iWbRd         WB-stage destination register
//   iWbRegWrite   WB instruction writes the register file
//   iMdStart      one-cycle pulse, a mult/div in EX starts the MD unit
//   oSelA/oSelB   ALU operand select: 00 regfile, 01 EX/MEM, 10 MEM/WB
//   oStall        hold PC and the IF/ID register
//   oBubble       load NOP control into ID/EX
//   oMdBusy       mult/div unit busy
//   oMdDone       HI/LO write enable, high in the last busy cycle
// ---------------------------------------------------------------------------
module hazard_fwd_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int MD_LATENCY = 32,
    parameter int CNT_W      = 6
) (
    input  logic                  iClk,
    input  logic                  iReset,
    input  logic [REG_ADDR_W-1:0] iIdRs,
    input  logic [REG_ADDR_W-1:0] iIdRt,
    input  logic                  iIdUseRs,
    input  logic                  iIdUseRt,
    input  logic                  iIdMdUse,
    input  logic [REG_ADDR_W-1:0] iExRd,
    input  logic                  iExMemRead,
    input  logic                  iExRegWrite,
    input  logic [REG_ADDR_W-1:0] iMemRd,
    input  logic                  iMemRegWrite,
    input  logic [REG_ADDR_W-1:0] iWbRd,
    input  logic                  iWbRegWrite,
    input  logic                  iMdStart,
    output logic [1:0]            oSelA,
    output logic [1:0]            oSelB,
    output logic                  oStall,
    output logic                  oBubble,
    output logic                  oMdBusy,
    output logic                  oMdDone
);

    localparam logic [CNT_W-1:0]      MD_LOAD  = CNT_W'(MD_LATENCY);
    localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

    localparam logic [1:0] SEL_REGFILE = 2'b00;
    localparam logic [1:0] SEL_EXMEM   = 2'b01;
    localparam logic [1:0] SEL_MEMWB   = 2'b10;

    // -----------------------------------------------------------------------
    // Mult/div sequencer state
    // -----------------------------------------------------------------------
    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } mdState_t;

    mdState_t         stateReg;
    mdState_t         stateNext;
    logic [CNT_W-1:0] cntReg;
    logic [CNT_W-1:0] cntNext;

    // High for exactly the first cycle after reset is released. Together with
    // iReset it forces every output quiet. This holds even if ID/EX inputs
    // already present a hazard pattern in that cycle.
    logic postResetReg;
    logic outputsBlocked;

    // EX-stage copies of the ID source operands
    logic [REG_ADDR_W-1:0] exRs;
    logic [REG_ADDR_W-1:0] exRt;
    logic                  exUseRs;
    logic                  exUseRt;

    logic mdBusyRaw;
    logic mdDoneRaw;
    logic luHaz;
    logic mdHaz;
    logic stallRaw;

    assign outputsBlocked = iReset | postResetReg;

    always_ff @(posedge iClk) begin
        if (iReset) begin
            stateReg     <= RUN;
            cntReg       <= '0;
            postResetReg <= 1'b1;
        end else begin
            stateReg     <= stateNext;
            cntReg       <= cntNext;
            postResetReg <= 1'b0;
        end
    end

    always_comb begin
        stateNext = stateReg;
        cntNext   = cntReg;
        case (stateReg)
            RUN: begin
                if (iMdStart) begin
                    cntNext   = MD_LOAD;
                    stateNext = MD_BUSY;
                end
            end
            MD_BUSY: begin
                if (iMdStart) begin
                    // A restart while busy only happens if stalling upstream is
                    // broken. Reloading keeps HI/LO timing tied to the newest
                    // start, and no error is raised.
                    cntNext = MD_LOAD;
                end else if (cntReg > CNT_ONE) begin
                    cntNext = cntReg - CNT_ONE;
                end else begin
                    // The cycle with cnt==1 is the HI/LO write cycle. The
                    // count then reaches zero and the unit is free again.
                    cntNext   = '0;
                    stateNext = RUN;
                end
            end
            default: begin
                cntNext   = '0;
                stateNext = RUN;
            end
        endcase
    end

    assign mdBusyRaw = (cntReg != '0);
    assign mdDoneRaw = (cntReg == CNT_ONE);

    // -----------------------------------------------------------------------
    // Hazard detection
    // -----------------------------------------------------------------------
    assign luHaz = iExMemRead & iExRegWrite & (iExRd != REG_ZERO) &
                   ((iIdUseRs & (iIdRs == iExRd)) |
                    (iIdUseRt & (iIdRt == iExRd)));

    // A start pulse counts as busy in its own cycle. Without this, an mfhi/mflo
    // directly behind the mult/div would slip into EX before the counter is
    // loaded.
    assign mdHaz = iIdMdUse & (mdBusyRaw | iMdStart);

    assign stallRaw = luHaz | mdHaz;

    assign oStall  = stallRaw & ~outputsBlocked;
    assign oBubble = stallRaw & ~outputsBlocked;
    assign oMdBusy = mdBusyRaw & ~iReset;
    assign oMdDone = mdDoneRaw & ~iReset;

    // -----------------------------------------------------------------------
    // EX source tracking. A stalled ID instruction stays in ID, so EX receives
    // a bubble. Clearing the use flags keeps the bubble from forwarding.
    // -----------------------------------------------------------------------
    always_ff @(posedge iClk) begin
        if (iReset) begin
            exRs    <= '0;
            exRt    <= '0;
            exUseRs <= 1'b0;
            exUseRt <= 1'b0;
        end else if (oStall) begin
            exRs    <= '0;
            exRt    <= '0;
            exUseRs <= 1'b0;
            exUseRt <= 1'b0;
        end else begin
            exRs    <= iIdRs;
            exRt    <= iIdRt;
            exUseRs <= iIdUseRs;
            exUseRt <= iIdUseRt;
        end
    end

    // -----------------------------------------------------------------------
    // Forwarding, one identical slice per ALU operand (0 = A/rs, 1 = B/rt).
    // MEM is checked first because it holds the younger result. $0 is
    // hard-wired to zero, so it never forwards.
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gOperand
            logic [REG_ADDR_W-1:0] src;
            logic                  srcUsed;
            logic                  memHit;
            logic                  wbHit;
            logic [1:0]            sel;

            assign src     = (gi == 0) ? exRs : exRt;
            assign srcUsed = (gi == 0) ? exUseRs : exUseRt;

            assign memHit = srcUsed & iMemRegWrite & (iMemRd != REG_ZERO) &
                            (iMemRd == src);
            assign wbHit  = srcUsed & iWbRegWrite & (iWbRd != REG_ZERO) &
                            (iWbRd == src);

            always_comb begin
                sel = SEL_REGFILE;
                if (memHit) begin
                    sel = SEL_EXMEM;
                end else if (wbHit) begin
                    sel = SEL_MEMWB;
                end
            end
        end
    endgenerate

    assign oSelA = outputsBlocked ? SEL_REGFILE : gOperand[0].sel;
    assign oSelB = outputsBlocked ? SEL_REGFILE : gOperand[1].sel;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_fwd_ctrl
//
// Directed testbench for hazard_fwd_ctrl with MD_LATENCY = 4.
// - A table of forwarding vectors. Each vector loads ID sources into EX, then
//   applies MEM/WB destinations and checks the operand selects and stall.
// - Hand-written sequences cover load-use, mult/div timing, combined hazards
//   and reset in the middle of a mult/div.
// ---------------------------------------------------------------------------
module tb_hazard_fwd_ctrl;

    localparam int AW  = 5;
    localparam int LAT = 4;

    logic          iClk = 1'b0;
    logic          iReset;
    logic [AW-1:0] iIdRs, iIdRt, iExRd, iMemRd, iWbRd;
    logic          iIdUseRs, iIdUseRt, iIdMdUse;
    logic          iExMemRead, iExRegWrite, iMemRegWrite, iWbRegWrite, iMdStart;
    logic [1:0]    oSelA, oSelB;
    logic          oStall, oBubble, oMdBusy, oMdDone;

    int checks = 0;
    int errors = 0;

    hazard_fwd_ctrl #(
        .REG_ADDR_W (AW),
        .MD_LATENCY (LAT),
        .CNT_W      (6)
    ) dut (
        .iClk         (iClk),
        .iReset       (iReset),
        .iIdRs        (iIdRs),
        .iIdRt        (iIdRt),
        .iIdUseRs     (iIdUseRs),
        .iIdUseRt     (iIdUseRt),
        .iIdMdUse     (iIdMdUse),
        .iExRd        (iExRd),
        .iExMemRead   (iExMemRead),
        .iExRegWrite  (iExRegWrite),
        .iMemRd       (iMemRd),
        .iMemRegWrite (iMemRegWrite),
        .iWbRd        (iWbRd),
        .iWbRegWrite  (iWbRegWrite),
        .iMdStart     (iMdStart),
        .oSelA        (oSelA),
        .oSelB        (oSelB),
        .oStall       (oStall),
        .oBubble      (oBubble),
        .oMdBusy      (oMdBusy),
        .oMdDone      (oMdDone)
    );

    always #5 iClk = ~iClk;

    typedef struct {
        logic [AW-1:0] idRs;
        logic [AW-1:0] idRt;
        logic          useRs;
        logic          useRt;
        logic [AW-1:0] memRd;
        logic          memWr;
        logic [AW-1:0] wbRd;
        logic          wbWr;
        logic [1:0]    expA;
        logic [1:0]    expB;
    } vec_t;

    localparam int NVEC = 10;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic clearInputs();
        iIdRs = '0; iIdRt = '0; iIdUseRs = 1'b0; iIdUseRt = 1'b0; iIdMdUse = 1'b0;
        iExRd = '0; iExMemRead = 1'b0; iExRegWrite = 1'b0;
        iMemRd = '0; iMemRegWrite = 1'b0; iWbRd = '0; iWbRegWrite = 1'b0;
        iMdStart = 1'b0;
    endtask

    task automatic checkMd(input string tag, input logic expStall, input logic expBusy,
                           input logic expDone);
        #1;
        check({tag, " stall"}, {1'b0, oStall},  {1'b0, expStall});
        check({tag, " bubble"}, {1'b0, oBubble}, {1'b0, expStall});
        check({tag, " busy"},  {1'b0, oMdBusy}, {1'b0, expBusy});
        check({tag, " done"},  {1'b0, oMdDone}, {1'b0, expDone});
        $display("%s: stall=%b busy=%b done=%b selA=%b selB=%b",
                 tag, oStall, oMdBusy, oMdDone, oSelA, oSelB);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        //                idRs  idRt  uRs   uRt   memRd mWr   wbRd  wWr   expA   expB
        vecs[0] = '{5'd8,  5'd3,  1'b1, 1'b1, 5'd8,  1'b1, 5'd8,  1'b1, 2'b01, 2'b00};
        vecs[1] = '{5'd8,  5'd3,  1'b1, 1'b1, 5'd8,  1'b0, 5'd8,  1'b1, 2'b10, 2'b00};
        vecs[2] = '{5'd8,  5'd3,  1'b1, 1'b1, 5'd8,  1'b0, 5'd8,  1'b0, 2'b00, 2'b00};
        vecs[3] = '{5'd0,  5'd0,  1'b1, 1'b1, 5'd0,  1'b1, 5'd0,  1'b1, 2'b00, 2'b00};
        vecs[4] = '{5'd7,  5'd7,  1'b1, 1'b0, 5'd2,  1'b1, 5'd7,  1'b1, 2'b10, 2'b00};
        vecs[5] = '{5'd4,  5'd4,  1'b1, 1'b1, 5'd4,  1'b1, 5'd1,  1'b1, 2'b01, 2'b01};
        vecs[6] = '{5'd4,  5'd6,  1'b1, 1'b1, 5'd6,  1'b1, 5'd4,  1'b1, 2'b10, 2'b01};
        vecs[7] = '{5'd31, 5'd30, 1'b1, 1'b1, 5'd31, 1'b1, 5'd30, 1'b1, 2'b01, 2'b10};
        vecs[8] = '{5'd12, 5'd12, 1'b0, 1'b1, 5'd12, 1'b1, 5'd12, 1'b1, 2'b00, 2'b01};
        vecs[9] = '{5'd9,  5'd10, 1'b1, 1'b1, 5'd11, 1'b1, 5'd13, 1'b1, 2'b00, 2'b00};

        // ---------------- reset state ----------------
        clearInputs();
        iReset = 1'b1;
        iMdStart = 1'b1;      // hazard-looking inputs must be masked by reset
        iIdMdUse = 1'b1;
        tick();
        #1;
        check("rst stall", {1'b0, oStall},  2'b00);
        check("rst bubble", {1'b0, oBubble}, 2'b00);
        check("rst busy",  {1'b0, oMdBusy}, 2'b00);
        check("rst selA",  oSelA, 2'b00);
        $display("reset: stall=%b busy=%b selA=%b selB=%b", oStall, oMdBusy, oSelA, oSelB);
        tick();
        iReset = 1'b0;
        clearInputs();
        #1;
        check("postrst stall", {1'b0, oStall},  2'b00);
        check("postrst busy",  {1'b0, oMdBusy}, 2'b00);
        check("postrst done",  {1'b0, oMdDone}, 2'b00);
        check("postrst selA",  oSelA, 2'b00);
        check("postrst selB",  oSelB, 2'b00);

        // ---------------- forwarding table ----------------
        for (int i = 0; i < NVEC; i++) begin
            iIdRs = vecs[i].idRs; iIdRt = vecs[i].idRt;
            iIdUseRs = vecs[i].useRs; iIdUseRt = vecs[i].useRt;
            iMemRegWrite = 1'b0; iWbRegWrite = 1'b0;
            tick();
            iMemRd = vecs[i].memRd; iMemRegWrite = vecs[i].memWr;
            iWbRd = vecs[i].wbRd;   iWbRegWrite = vecs[i].wbWr;
            #1;
            check($sformatf("vec%0d selA", i), oSelA, vecs[i].expA);
            check($sformatf("vec%0d selB", i), oSelB, vecs[i].expB);
            check($sformatf("vec%0d stall", i), {1'b0, oStall}, 2'b00);
            $display("vec %0d: selA=%b selB=%b stall=%b", i, oSelA, oSelB, oStall);
        end
        clearInputs();
        tick();

        // ---------------- load-use ----------------
        iExRd = 5'd9; iExMemRead = 1'b1; iExRegWrite = 1'b1;
        iIdRs = 5'd9; iIdUseRs = 1'b1;
        #1;
        check("lu stall", {1'b0, oStall},  2'b01);
        check("lu bubble", {1'b0, oBubble}, 2'b01);
        $display("lu c0: stall=%b bubble=%b", oStall, oBubble);
        tick();
        iExRd = '0; iExMemRead = 1'b0; iExRegWrite = 1'b0;
        iMemRd = 5'd9; iMemRegWrite = 1'b1;
        #1;
        check("lu c1 stall", {1'b0, oStall}, 2'b00);
        check("lu c1 selA", oSelA, 2'b00);
        $display("lu c1: stall=%b selA=%b", oStall, oSelA);
        tick();
        iMemRegWrite = 1'b0; iWbRd = 5'd9; iWbRegWrite = 1'b1; iIdUseRs = 1'b0;
        #1;
        check("lu c2 selA", oSelA, 2'b10);
        check("lu c2 stall", {1'b0, oStall}, 2'b00);
        $display("lu c2: stall=%b selA=%b", oStall, oSelA);
        clearInputs();
        tick();

        // ---------------- mult/div latency ----------------
        iMdStart = 1'b1; iIdMdUse = 1'b1;
        iIdRs = 5'd5; iIdUseRs = 1'b1; iMemRd = 5'd5; iMemRegWrite = 1'b1;
        checkMd("md t+0", 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= LAT + 1; k++) begin
            tick();
            iMdStart = 1'b0;
            checkMd($sformatf("md t+%0d", k), k <= LAT, k <= LAT, k == LAT);
            check($sformatf("md t+%0d selA", k), oSelA, 2'b00);
        end
        tick();
        #1;
        check("md released selA", oSelA, 2'b01);
        $display("md released: selA=%b", oSelA);
        clearInputs();
        tick();

        // ---------------- combined load-use + mult/div ----------------
        iMdStart = 1'b1; iIdMdUse = 1'b1;
        iMemRd = 5'd9; iMemRegWrite = 1'b1; iWbRd = 5'd9; iWbRegWrite = 1'b1;
        iIdRt = 5'd9; iIdUseRt = 1'b1;
        checkMd("cmb t+0", 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= LAT + 1; k++) begin
            tick();
            iMdStart = 1'b0;
            if (k == LAT) begin
                iExRd = 5'd9; iExMemRead = 1'b1; iExRegWrite = 1'b1;
            end else begin
                iExRd = '0; iExMemRead = 1'b0; iExRegWrite = 1'b0;
            end
            checkMd($sformatf("cmb t+%0d", k), k <= LAT, k <= LAT, k == LAT);
            check($sformatf("cmb t+%0d selB", k), oSelB, 2'b00);
        end
        clearInputs();
        tick();

        // ---------------- reset during mult/div ----------------
        iMdStart = 1'b1; iIdMdUse = 1'b1;
        iIdRs = 5'd5; iIdUseRs = 1'b1; iMemRd = 5'd5; iMemRegWrite = 1'b1;
        checkMd("rmd t+0", 1'b1, 1'b0, 1'b0);
        tick();
        iMdStart = 1'b0;
        checkMd("rmd t+1", 1'b1, 1'b1, 1'b0);
        tick();
        iReset = 1'b1;
        checkMd("rmd t+2", 1'b0, 1'b0, 1'b0);
        check("rmd t+2 selA", oSelA, 2'b00);
        tick();
        iReset = 1'b0;
        checkMd("rmd t+3", 1'b0, 1'b0, 1'b0);
        check("rmd t+3 selA", oSelA, 2'b00);
        tick();
        iMdStart = 1'b1;
        checkMd("rmd2 t+0", 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= LAT + 1; k++) begin
            tick();
            iMdStart = 1'b0;
            checkMd($sformatf("rmd2 t+%0d", k), k <= LAT, k <= LAT, k == LAT);
        end
        clearInputs();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
